// File: rtl/pipeline_ctrl_if.sv
// Pipeline hazard-control bundle.
// The pipeline side (master) drives the hazard sources: ID/EX register
// indices, load/branch/mul-div flags, the mul/div done pulse and the MEM
// handshake. The controller side (slave) drives back the stage write enables,
// the bubble/flush controls, the mul/div start pulse, the sticky timeout flag
// and the stall-cycle counter.
interface pipeline_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  ex_rd;
  logic        ex_mem_read;
  logic        ex_branch_taken;
  logic        ex_md_op;
  logic        md_done;
  logic        mem_req;
  logic        dmem_ready;

  logic        pc_write;
  logic        if_id_write;
  logic        id_ex_write;
  logic        ex_mem_write;
  logic        control_sel;
  logic        ex_bubble;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        md_start;
  logic        md_err;
  logic [31:0] stall_cycles;

  modport master (
    output id_rs1, id_rs2, ex_rd, ex_mem_read, ex_branch_taken, ex_md_op, md_done,
           mem_req, dmem_ready,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write, control_sel, ex_bubble,
           if_id_flush, id_ex_flush, md_start, md_err, stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, ex_rd, ex_mem_read, ex_branch_taken, ex_md_op, md_done,
           mem_req, dmem_ready,
    output pc_write, if_id_write, id_ex_write, ex_mem_write, control_sel, ex_bubble,
           if_id_flush, id_ex_flush, md_start, md_err, stall_cycles
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard controller.
// Resolves memory stalls, taken-branch flushes, multi-cycle mul/div issue and
// load-use hazards, in that priority, via stage write enables, bubbles and
// flushes. A mul/div wait aborts after MD_TIMEOUT cycles and sets a sticky
// md_err flag.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - pipeline_ctrl_if.slave: hazard inputs in, pipeline controls out
// Configuration:
//   PIPELINE_CTRL_STALL_CNT_EN - when defined, bus.stall_cycles counts cycles
//   with pc_write=0 (wrapping); otherwise it is tied to zero.
module pipeline_ctrl #(
  parameter int unsigned MD_TIMEOUT = 64  // 2..127
) (
  input logic           clk,
  input logic           rst,
  pipeline_ctrl_if.slave bus
);

  localparam logic [6:0] LastCnt = 7'(MD_TIMEOUT - 1);

  typedef enum logic [1:0] {StRun, StMdWait, StMemWait} state_e;

  state_e     state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  logic pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic control_sel, ex_bubble, if_id_flush, id_ex_flush, md_start;
  logic mem_stall, load_use, run_eval;

  assign mem_stall = bus.mem_req && !bus.dmem_ready;
  // x0 is never a real dependency, so a load to x0 never stalls.
  assign load_use  = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                     ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    control_sel  = 1'b0;
    ex_bubble    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    md_start     = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    run_eval     = 1'b0;

    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
          state_d = StMemWait;
        end else begin
          run_eval = 1'b1;
        end
      end
      StMemWait: begin
        if (!bus.dmem_ready) begin
          {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
        end else begin
          // Ready cycle behaves like RUN minus the memory condition.
          state_d  = StRun;
          run_eval = 1'b1;
        end
      end
      StMdWait: begin
        cnt_d = cnt_q + 7'd1;
        if (bus.md_done) begin
          // Completion wins over a coincident timeout.
          state_d = StRun;
        end else if (cnt_q == LastCnt) begin
          err_d   = 1'b1;
          state_d = StRun;
        end else begin
          {pc_write, if_id_write, id_ex_write} = 3'b000;
          ex_bubble = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase

    if (run_eval) begin
      if (bus.ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (bus.ex_md_op) begin
        md_start = 1'b1;
        {pc_write, if_id_write, id_ex_write} = 3'b000;
        ex_bubble = 1'b1;
        state_d   = StMdWait;
        cnt_d     = 7'd0;
      end else if (load_use) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        control_sel = 1'b1;
      end
    end

    if (rst) begin
      {pc_write, if_id_write, id_ex_write, ex_mem_write} = 4'b0000;
      control_sel = 1'b0;
      ex_bubble   = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      md_start    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= 7'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.if_id_write  = if_id_write;
  assign bus.id_ex_write  = id_ex_write;
  assign bus.ex_mem_write = ex_mem_write;
  assign bus.control_sel  = control_sel;
  assign bus.ex_bubble    = ex_bubble;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.md_start     = md_start;
  assign bus.md_err       = err_q;

`ifdef PIPELINE_CTRL_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 32'd0;
    end else if (!pc_write) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_q;
`else
  assign bus.stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (MD_TIMEOUT=8). Inputs change on the
// falling edge; outputs are sampled 1 ns later, before the next rising edge.
// Output vector order:
//   {pc_write, if_id_write, id_ex_write, ex_mem_write,
//    control_sel, ex_bubble, if_id_flush, id_ex_flush, md_start, md_err}
module tb_pipeline_ctrl;

  localparam logic [9:0] RstO    = 10'b0000_000000;
  localparam logic [9:0] AllEn   = 10'b1111_000000;
  localparam logic [9:0] Frozen  = 10'b0000_000000;
  localparam logic [9:0] LoadUse = 10'b0011_100000;
  localparam logic [9:0] Branch  = 10'b1111_001100;
  localparam logic [9:0] MdIssue = 10'b0001_010010;
  localparam logic [9:0] MdWait  = 10'b0001_010000;
  localparam logic [9:0] ErrBit  = 10'b0000_000001;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int unsigned exp_stall = 0;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(.MD_TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] outs();
    return {bus.pc_write, bus.if_id_write, bus.id_ex_write, bus.ex_mem_write,
            bus.control_sel, bus.ex_bubble, bus.if_id_flush, bus.id_ex_flush,
            bus.md_start, bus.md_err};
  endfunction

  task automatic clear_inputs();
    bus.id_rs1          = 5'd0;
    bus.id_rs2          = 5'd0;
    bus.ex_rd           = 5'd0;
    bus.ex_mem_read     = 1'b0;
    bus.ex_branch_taken = 1'b0;
    bus.ex_md_op        = 1'b0;
    bus.md_done         = 1'b0;
    bus.mem_req         = 1'b0;
    bus.dmem_ready      = 1'b0;
  endtask

  // Check outputs and the stall counter for the current cycle, then advance.
  task automatic cyc(input string tag, input logic [9:0] exp);
    logic [9:0]  obs;
    logic [31:0] exp_cnt;
    #1;
    obs = outs();
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
`ifdef PIPELINE_CTRL_STALL_CNT_EN
    exp_cnt = exp_stall;
`else
    exp_cnt = 32'd0;
`endif
    checks++;
    assert (bus.stall_cycles === exp_cnt) else begin
      failures++;
      $error("FAIL %s_stall: observed %0d expected %0d", tag, bus.stall_cycles, exp_cnt);
    end
    if (rst) exp_stall = 0;
    else if (!exp[9]) exp_stall++;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    cyc("reset", RstO);
    rst = 1'b0;
    cyc("idle", AllEn);

    // Load-use via rs2, then bubble leaves EX.
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5; bus.id_rs2 = 5'd5;
    cyc("lu_rs2", LoadUse);
    bus.ex_mem_read = 1'b0;
    cyc("lu_done", AllEn);
    // Load to x0 never stalls.
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0;
    cyc("lu_x0", AllEn);
    bus.ex_rd = 5'd7; bus.id_rs1 = 5'd7;
    cyc("lu_rs1", LoadUse);
    // Branch beats load-use.
    bus.ex_branch_taken = 1'b1;
    cyc("br_lu", Branch);
    clear_inputs();

    // Mem stall beats branch; three frozen cycles, then ready resolves branch.
    bus.mem_req = 1'b1; bus.ex_branch_taken = 1'b1;
    cyc("mem0", Frozen);
    cyc("mem1", Frozen);
    cyc("mem2", Frozen);
    bus.dmem_ready = 1'b1;
    cyc("mem_ready", Branch);
    clear_inputs();
    cyc("mem_after", AllEn);

    // Mem wait resolving into a mul/div issue.
    bus.mem_req = 1'b1; bus.ex_md_op = 1'b1;
    cyc("mem_md0", Frozen);
    bus.dmem_ready = 1'b1;
    cyc("mem_md_issue", MdIssue);
    clear_inputs();
    bus.md_done = 1'b1;
    cyc("mem_md_done", AllEn);

    // md_done in RUN is ignored.
    cyc("done_in_run", AllEn);
    bus.md_done = 1'b0;

    // Mul/div completing after five wait cycles; op stays in EX meanwhile.
    bus.ex_md_op = 1'b1;
    cyc("md_issue", MdIssue);
    for (int i = 0; i < 5; i++) cyc("md_wait", MdWait);
    bus.md_done = 1'b1;
    cyc("md_done", AllEn);
    clear_inputs();
    cyc("md_after", AllEn);

    // Timeout: issue + 7 stalled waits, release on the 8th wait cycle.
    bus.ex_md_op = 1'b1;
    cyc("to_issue", MdIssue);
    bus.ex_md_op = 1'b0;
    for (int i = 0; i < 7; i++) cyc("to_wait", MdWait);
    cyc("to_release", AllEn);
    cyc("to_err", AllEn | ErrBit);
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd3; bus.id_rs1 = 5'd3;
    cyc("to_err_lu", LoadUse | ErrBit);
    clear_inputs();
    cyc("to_err_held", AllEn | ErrBit);

    // Reset clears md_err; output check skipped while stale err_q is visible.
    rst = 1'b1;
    @(negedge clk);
    exp_stall = 0;
    rst = 1'b0;
    cyc("err_cleared", AllEn);

    // md_done coincident with timeout counts as completion.
    bus.ex_md_op = 1'b1;
    cyc("co_issue", MdIssue);
    bus.ex_md_op = 1'b0;
    for (int i = 0; i < 7; i++) cyc("co_wait", MdWait);
    bus.md_done = 1'b1;
    cyc("co_done", AllEn);
    bus.md_done = 1'b0;
    cyc("co_no_err", AllEn);

    // Reset in the 2nd MD_WAIT cycle aborts the wait.
    bus.ex_md_op = 1'b1;
    cyc("rw_issue", MdIssue);
    bus.ex_md_op = 1'b0;
    cyc("rw_wait1", MdWait);
    rst = 1'b1;
    cyc("rw_rst", RstO);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cyc("rw_run", AllEn);

    // Reset in MEM_WAIT aborts the wait even with dmem_ready low.
    bus.mem_req = 1'b1;
    cyc("rm_mem", Frozen);
    rst = 1'b1;
    cyc("rm_rst", RstO);
    rst = 1'b0;
    bus.mem_req = 1'b0;
    cyc("rm_run", AllEn);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter: MD_TIMEOUT, default 64; maximum MD_WAIT cycles before abort (range 2..127).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 id_rs1, id_rs2  in  5 each  source registers of the ID-stage instruction.
REQ-005 ex_rd  in  5  destination register of the EX-stage instruction.
REQ-006 ex_mem_read  in  1  EX-stage instruction is a load.
REQ-007 ex_branch_taken  in  1  EX resolved a taken branch or jump.
REQ-008 ex_md_op  in  1  EX holds a multi-cycle mul/div op.
REQ-009 md_done  in  1  single-cycle pulse from the mul/div unit.
REQ-010 mem_req, dmem_ready  in  1 each  MEM-stage access request; data memory ready.
REQ-011 pc_write, if_id_write, id_ex_write, ex_mem_write  out  1 each  stage write enables.
REQ-012 control_sel  out  1  inject bubble into ID/EX; ex_bubble  out  1  inject bubble into EX/MEM.
REQ-013 if_id_flush, id_ex_flush  out  1 each  clear the register.
REQ-014 md_start  out  1  one-cycle start pulse; md_err  out  1  sticky timeout flag.
REQ-015 stall_cycles  out  32  count of cycles with pc_write=0.

Function
REQ-016 FSM states: RUN, MD_WAIT, MEM_WAIT; outputs combinational from state and inputs.
REQ-017 Default outputs: all four write enables 1; control_sel, ex_bubble, flushes, md_start 0.
REQ-018 RUN priority, highest first: mem stall, branch flush, md issue, load-use.
REQ-019 Mem stall (mem_req=1, dmem_ready=0): all write enables 0, no bubbles or flushes; next state MEM_WAIT.
REQ-020 Branch flush (ex_branch_taken=1): if_id_flush=1, id_ex_flush=1, enables 1; load-use ignored; stay RUN.
REQ-021 Md issue (ex_md_op=1): md_start=1; pc_write, if_id_write, id_ex_write 0; ex_bubble=1; next state MD_WAIT with timeout counter loaded to 0.
REQ-022 Load-use: ex_mem_read=1, ex_rd!=0, and ex_rd equal to id_rs1 or id_rs2. Response: pc_write=0, if_id_write=0, control_sel=1; stay RUN; ex_rd=0 never stalls.
REQ-023 MEM_WAIT: while dmem_ready=0, all enables 0. On dmem_ready=1, outputs equal the RUN evaluation with the mem condition excluded, and the next state follows that evaluation.
REQ-024 MD_WAIT: pc_write, if_id_write, id_ex_write 0; ex_bubble=1; md_start 0; counter increments every cycle.
REQ-025 MD_WAIT exit on md_done=1: enables 1, ex_bubble 0; next RUN; md_start never re-pulses for the same op.
REQ-026 MD_WAIT timeout: when counter reaches MD_TIMEOUT-1 without md_done, md_err is set and held, enables are 1 that cycle, and next state is RUN.
REQ-027 md_done and timeout in the same cycle count as completion; md_err is not set.
REQ-028 md_done outside MD_WAIT is ignored.

Reset
REQ-029 With rst=1 at a clock edge: state=RUN, timeout counter=0, md_err=0, stall_cycles=0.
REQ-030 While rst=1: all write enables 0; md_start, control_sel, ex_bubble, flushes 0.
REQ-031 Reset in MD_WAIT or MEM_WAIT aborts the wait with no md_start or md_err afterward.

Configuration
REQ-032 Macro PIPELINE_CTRL_STALL_CNT_EN defined: stall_cycles increments on each non-reset cycle with pc_write=0 and wraps 0xFFFFFFFF to 0.
REQ-033 Macro undefined: stall_cycles is tied to 0 and no counter register exists.

Verification
REQ-034 Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5 -> pc_write=0, if_id_write=0, control_sel=1 for 1 cycle. Same with ex_rd=0 -> no stall.
REQ-035 Branch and load-use together: ex_branch_taken=1 plus a load-use match -> both flushes=1, pc_write=1, control_sel=0.
REQ-036 Mul/div: ex_md_op=1, md_done 5 cycles later -> md_start high 1 cycle, ex_bubble high 6 cycles, RUN after done, md_err=0.
REQ-037 Timeout: MD_TIMEOUT=8, no md_done -> return to RUN after 8 stalled cycles, md_err=1 held until rst.
REQ-038 Mem wait: mem_req=1, dmem_ready=0 for 3 cycles -> all enables 0 for 3 cycles, 1 on the ready cycle; with macro, stall_cycles=3.
REQ-039 Reset mid-wait: rst in the 2nd MD_WAIT cycle -> next cycle RUN, md_err=0, stall_cycles=0, no md_start.
